// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared FSM encoding and bank geometry for the word serializer
package word_serializer_pkg;
    localparam int WORDS = 8;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: burst request inputs plus the valid/ready word stream and status
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int N = 32
) ();
    logic               start;
    logic [SEL_W-1:0]   len;
    logic [WORDS*N-1:0] in_data;
    logic               out_ready;
    logic               out_valid;
    logic [N-1:0]       out_data;
    logic               out_last;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               done;
    modport master (
        output start, len, in_data, out_ready,
        input  out_valid, out_data, out_last, sel, busy, done
    );
    modport slave (
        input  start, len, in_data, out_ready,
        output out_valid, out_data, out_last, sel, busy, done
    );
endinterface

// File: rtl/word_serializer_mux8to1.sv
// word_serializer_mux8to1: selects one of the eight bank words by index
module word_serializer_mux8to1
    import word_serializer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [WORDS-1:0][N-1:0] words,
    input  logic [SEL_W-1:0]        select,
    output logic [N-1:0]            y
);
    assign y = words[select];
endmodule

// File: rtl/word_serializer.sv
// word_serializer: captures an 8-word bank on start and streams it out one word per accepted beat
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int N = 32
) (
    input logic clk,
    input logic rst,
    word_serializer_if.slave bus
);
    state_t                  state;
    logic [WORDS-1:0][N-1:0] bank;
    logic [SEL_W-1:0]        len_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic [N-1:0]            mux_y;

    word_serializer_mux8to1 #(.N(N)) u_mux (
        .words  (bank),
        .select (sel_q),
        .y      (mux_y)
    );

    // Burst FSM: capture on start, advance sel per accepted beat, one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bank    <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    bank    <= bus.in_data;
                    len_q   <= bus.len;
                    sel_q   <= '0;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state   <= STREAM;
                end
                STREAM: if (bus.out_ready) begin
                    if (sel_q == len_q) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                DONE: begin
                    sel_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = valid_q ? mux_y : '0;
    assign bus.out_last  = valid_q && (sel_q == len_q);
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed and randomized bursts checked against a beat-count reference model
module tb_word_serializer;
    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    word_serializer_if #(.N(N)) bus ();

    word_serializer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_sel"},   32'(bus.sel),       32'd0);
        chk({tag, "_data"},  bus.out_data,       32'd0);
        chk({tag, "_last"},  32'(bus.out_last),  32'd0);
    endtask

    function automatic logic ready_of(input int mode, input int cyc);
        return mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom % 2);
    endfunction

    // Expected stream: beat k carries word k of the captured bank; one beat per cycle where ready is high.
    task automatic burst(input logic [2:0] l, input logic [8*N-1:0] d, input int mode, input bit noise);
        logic [N-1:0] w [8];
        int acc;
        int cyc;
        for (int k = 0; k < 8; k++) w[k] = d[k*N +: N];
        bus.start     = 1'b1;
        bus.len       = l;
        bus.in_data   = d;
        bus.out_ready = 1'b0;
        @(negedge clk);
        acc = 0;
        cyc = 0;
        while (acc <= int'(l) && cyc < 100) begin
            chk("valid", 32'(bus.out_valid), 32'd1);
            chk("sel",   32'(bus.sel),       32'(acc));
            chk("data",  bus.out_data,       w[acc]);
            chk("last",  32'(bus.out_last),  32'(acc == int'(l)));
            chk("busy",  32'(bus.busy),      32'd1);
            chk("done",  32'(bus.done),      32'd0);
            bus.start     = noise ? 1'($urandom % 2) : 1'b0;
            bus.in_data   = noise ? {8{$urandom}} : d;
            bus.len       = noise ? 3'($urandom) : l;
            bus.out_ready = ready_of(mode, cyc);
            if (bus.out_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        chk("beats", 32'(acc), 32'(int'(l) + 1));
        chk("done_pulse", 32'(bus.done),      32'd1);
        chk("done_valid", 32'(bus.out_valid), 32'd0);
        chk("done_busy",  32'(bus.busy),      32'd1);
        chk("done_data",  bus.out_data,       32'd0);
        bus.start = noise;
        @(negedge clk);
        chk_quiet("idle");
        bus.start = 1'b0;
    endtask

    initial begin
        logic [8*N-1:0] d;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        for (int k = 0; k < 8; k++) d[k*N +: N] = 32'h1000_0000 + 32'(k);
        burst(3'd7, d, 0, 1'b0);

        d = {8{$urandom}};
        for (int k = 0; k < 8; k++) d[k*N +: N] = $urandom;
        burst(3'd3, d, 1, 1'b0);

        d = '0;
        d[N-1:0] = 32'hDEAD_BEEF;
        burst(3'd0, d, 0, 1'b0);

        for (int k = 0; k < 8; k++) d[k*N +: N] = $urandom;
        burst(3'($urandom), d, 2, 1'b1);
        for (int k = 0; k < 8; k++) d[k*N +: N] = $urandom;
        burst(3'd5, d, 0, 1'b1);

        for (int k = 0; k < 8; k++) d[k*N +: N] = 32'hA0A0_0000 + 32'(k);
        bus.start     = 1'b1;
        bus.len       = 3'd7;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_run_sel", 32'(bus.sel), 32'(k));
            @(negedge clk);
        end
        chk("rst_at_sel3", 32'(bus.sel), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_mid_reset");
        burst(3'd7, d, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++) d[k*N +: N] = $urandom;
            burst(3'($urandom), d, 2, 1'(i % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
